inst_mem_loader: RTL and testbench

- Instruction-side memory responder for the RV32I pipeline CPU.
- Answers the fetch stage's word address with the instruction word, as a combinational read path so existing IF timing is unchanged.
- Owns a byte-serial program loader (valid/ready stream) that packs little-endian bytes into words and writes them sequentially from word 0.
- Holds the CPU in reset through cpu_rst_n_o while a load is in progress.

---
 rtl/inst_mem_loader.sv | 150 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory for the RV32I core with a byte-serial program loader that holds the core in reset while loading.
// Define INST_MEM_PRELOAD_EN to let the core run straight out of reset.
module inst_mem_loader #(
   parameter int    ADDR_W    = 12,
   parameter string INIT_FILE = "inst.hex"
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       inst_addr_i,
   output logic [31:0]       inst_o,
   input  logic              ld_start_i,
   input  logic [ADDR_W:0]   ld_len_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_data_i,
   output logic              ld_ready_o,
   output logic              ld_busy_o,
   output logic              ld_done_o,
   output logic              cpu_rst_n_o,
   output logic              fetch_err_o
);

   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [31:0]     NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_RUN
   } state_t;

   logic [31:0] mem [DEPTH];

`ifdef INST_MEM_PRELOAD_EN
   localparam state_t RST_STATE   = S_RUN;
   localparam logic   RST_CPU_RUN = 1'b1;
`else
   localparam state_t RST_STATE   = S_IDLE;
   localparam logic   RST_CPU_RUN = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [23:0]       buf_q, buf_d;
   logic              fetch_err_q, fetch_err_d;
   logic              cpu_run_q, cpu_run_d;

   logic              load_start;
   logic              byte_acc;
   logic              mem_we;
   logic [31:0]       wr_word;
   logic [ADDR_W-1:0] word_idx;
   logic              fetch_ok;

   assign load_start = (state_q == S_IDLE || state_q == S_RUN) && ld_start_i && (ld_len_i != '0);
   assign byte_acc   = (state_q == S_LOAD) && ld_valid_i;
   assign wr_word    = {ld_data_i, buf_q};

   // Bytes 0..2 of a word park in their own lane; byte 3 goes straight to memory.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         assign buf_d[8*gi +: 8] = (byte_acc && cnt_q == 2'(gi)) ? ld_data_i : buf_q[8*gi +: 8];
      end
   endgenerate

   assign word_idx = inst_addr_i[ADDR_W+1:2];
   assign fetch_ok = (inst_addr_i[1:0] == 2'b00) && (inst_addr_i[31:ADDR_W+2] == '0);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      mem_we      = 1'b0;
      fetch_err_d = fetch_err_q;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (load_start) begin
               state_d = S_LOAD;
               ptr_d   = '0;
               cnt_d   = '0;
               len_d   = (ld_len_i > DEPTH_L) ? DEPTH_L : ld_len_i;
            end
         end
         S_LOAD: begin
            if (byte_acc) begin
               if (cnt_q == 2'd3) begin
                  mem_we = 1'b1;
                  ptr_d  = ptr_q + (ADDR_W + 1)'(1);
                  cnt_d  = '0;
                  if (ptr_d == len_q) begin
                     state_d = S_DONE;
                  end
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         S_DONE: state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
      if (load_start) begin
         fetch_err_d = 1'b0;
      end else if (state_q == S_RUN && !fetch_ok) begin
         fetch_err_d = 1'b1;
      end
   end

   // Registered so the core sees reset release exactly as the FSM enters RUN.
   assign cpu_run_d = (state_d == S_RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RST_STATE;
         ptr_q       <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         buf_q       <= '0;
         fetch_err_q <= 1'b0;
         cpu_run_q   <= RST_CPU_RUN;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         fetch_err_q <= fetch_err_d;
         cpu_run_q   <= cpu_run_d;
      end
   end

   // A reset on the same edge as a word completion suppresses the write.
   always_ff @(posedge clk) begin
      if (mem_we && rst_n) begin
         mem[ptr_q[ADDR_W-1:0]] <= wr_word;
      end
   end

   assign inst_o      = (state_q == S_RUN && fetch_ok) ? mem[word_idx] : NOP;
   assign ld_ready_o  = (state_q == S_LOAD);
   assign ld_busy_o   = (state_q == S_LOAD) || (state_q == S_DONE);
   assign ld_done_o   = (state_q == S_DONE);
   assign cpu_rst_n_o = cpu_run_q;
   assign fetch_err_o = fetch_err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomised bench for inst_mem_loader: byte streams are checked against a word-level memory model.
module tb_inst_mem_loader;

   localparam int ADDR_W = 12;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [31:0]       inst_addr_i;
   logic [31:0]       inst_o;
   logic              ld_start_i;
   logic [ADDR_W:0]   ld_len_i;
   logic              ld_valid_i;
   logic [7:0]        ld_data_i;
   logic              ld_ready_o;
   logic              ld_busy_o;
   logic              ld_done_o;
   logic              cpu_rst_n_o;
   logic              fetch_err_o;

   int checks = 0;
   int passed = 0;

   logic [31:0] model_mem   [DEPTH];
   bit          model_known [DEPTH];
   logic [7:0]  tx_q [$];

   always #5 clk = ~clk;

   inst_mem_loader #(.ADDR_W(ADDR_W), .INIT_FILE("inst.hex")) dut (
      .clk(clk), .rst_n(rst_n), .inst_addr_i(inst_addr_i), .inst_o(inst_o),
      .ld_start_i(ld_start_i), .ld_len_i(ld_len_i), .ld_valid_i(ld_valid_i),
      .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o), .ld_busy_o(ld_busy_o),
      .ld_done_o(ld_done_o), .cpu_rst_n_o(cpu_rst_n_o), .fetch_err_o(fetch_err_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int len);
      ld_start_i = 1'b1;
      ld_len_i   = (ADDR_W + 1)'(len);
      tick();
      ld_start_i = 1'b0;
      ld_len_i   = '0;
   endtask

   // Model: every complete group of four streamed bytes becomes one little-endian word, from word 0.
   function automatic void model_load(input int max_words);
      int nw;
      nw = tx_q.size() / 4;
      if (nw > max_words) nw = max_words;
      for (int w = 0; w < nw; w++) begin
         model_mem[w]   = tx_q[4*w] | (tx_q[4*w+1] << 8) | (tx_q[4*w+2] << 16) | (tx_q[4*w+3] << 24);
         model_known[w] = 1'b1;
      end
   endfunction

   // Streams tx_q; gap < 0 means a random 0..3 idle cycles after each byte.
   task automatic send_bytes(input int gap, input bit poke_start, output int early_done, output logic final_done);
      int g;
      early_done = 0;
      final_done = 1'b0;
      for (int i = 0; i < tx_q.size(); i++) begin
         ld_valid_i = 1'b1;
         ld_data_i  = tx_q[i];
         if (poke_start) begin
            ld_start_i = 1'($urandom_range(0, 1));
            ld_len_i   = (ADDR_W + 1)'($urandom_range(1, 8));
         end
         tick();
         ld_valid_i = 1'b0;
         ld_start_i = 1'b0;
         ld_len_i   = '0;
         if (i == tx_q.size() - 1) begin
            final_done = ld_done_o;
         end else begin
            if (ld_done_o) early_done++;
            g = (gap < 0) ? $urandom_range(0, 3) : gap;
            for (int k = 0; k < g; k++) begin
               tick();
               if (ld_done_o) early_done++;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      inst_addr_i = 32'h0;
      #1;
      checks++; if (ld_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ld_ready_o); else passed++;
      checks++; if (ld_busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", ld_busy_o); else passed++;
      checks++; if (ld_done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", ld_done_o); else passed++;
      checks++; if (fetch_err_o !== 1'b0) $display("FAIL reset_fetch_err: got %b want 0", fetch_err_o); else passed++;
`ifdef INST_MEM_PRELOAD_EN
      checks++; if (cpu_rst_n_o !== 1'b1) $display("FAIL reset_cpu_rst_n: got %b want 1", cpu_rst_n_o); else passed++;
`else
      checks++; if (cpu_rst_n_o !== 1'b0) $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n_o); else passed++;
      checks++; if (inst_o !== NOP) $display("FAIL reset_inst: got %h want %h", inst_o, NOP); else passed++;
`endif
   endtask

   // Known two-word program, streamed with the given gap between bytes.
   task automatic test_known_load(input string tag, input int gap);
      int   early;
      logic fin;
      tx_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      start_load(2);
      checks++; if (ld_ready_o !== 1'b1 || ld_busy_o !== 1'b1) $display("FAIL %s_load_flags: got ready=%b busy=%b want 1 1", tag, ld_ready_o, ld_busy_o); else passed++;
      checks++; if (cpu_rst_n_o !== 1'b0) $display("FAIL %s_cpu_held: got %b want 0", tag, cpu_rst_n_o); else passed++;
      send_bytes(gap, 1'b0, early, fin);
      model_load(2);
      checks++; if (early !== 0) $display("FAIL %s_early_done: got %0d pulses want 0", tag, early); else passed++;
      checks++; if (fin !== 1'b1) $display("FAIL %s_done_pulse: got %b want 1", tag, fin); else passed++;
      checks++; if (ld_busy_o !== 1'b1 || ld_ready_o !== 1'b0 || cpu_rst_n_o !== 1'b0) $display("FAIL %s_done_flags: got busy=%b ready=%b cpu=%b want 1 0 0", tag, ld_busy_o, ld_ready_o, cpu_rst_n_o); else passed++;
      tick();
      checks++; if (cpu_rst_n_o !== 1'b1 || ld_done_o !== 1'b0 || ld_busy_o !== 1'b0) $display("FAIL %s_run_flags: got cpu=%b done=%b busy=%b want 1 0 0", tag, cpu_rst_n_o, ld_done_o, ld_busy_o); else passed++;
      inst_addr_i = 32'h0; #1;
      checks++; if (inst_o !== 32'h00A00513) $display("FAIL %s_word0: got %h want 00a00513", tag, inst_o); else passed++;
      inst_addr_i = 32'h4; #1;
      checks++; if (inst_o !== 32'h00100593) $display("FAIL %s_word1: got %h want 00100593", tag, inst_o); else passed++;
      inst_addr_i = 32'h0;
      tick();
   endtask

   task automatic test_fetch_err();
      int   early;
      logic fin;
      inst_addr_i = 32'h0;
      tick();
      checks++; if (fetch_err_o !== 1'b0) $display("FAIL ferr_clean: got %b want 0", fetch_err_o); else passed++;
      inst_addr_i = 32'h0000_4000; #1;
      checks++; if (inst_o !== NOP) $display("FAIL ferr_range_inst: got %h want %h", inst_o, NOP); else passed++;
      tick();
      checks++; if (fetch_err_o !== 1'b1) $display("FAIL ferr_range_flag: got %b want 1", fetch_err_o); else passed++;
      inst_addr_i = 32'h0000_0002; #1;
      checks++; if (inst_o !== NOP) $display("FAIL ferr_misaligned_inst: got %h want %h", inst_o, NOP); else passed++;
      inst_addr_i = 32'h0;
      tick(); tick(); tick();
      checks++; if (fetch_err_o !== 1'b1) $display("FAIL ferr_sticky: got %b want 1", fetch_err_o); else passed++;
      checks++; if (inst_o !== model_mem[0]) $display("FAIL ferr_read_after: got %h want %h", inst_o, model_mem[0]); else passed++;
      start_load(0);
      checks++; if (ld_busy_o !== 1'b0 || cpu_rst_n_o !== 1'b1 || fetch_err_o !== 1'b1) $display("FAIL len0_ignored: got busy=%b cpu=%b err=%b want 0 1 1", ld_busy_o, cpu_rst_n_o, fetch_err_o); else passed++;
      start_load(1);
      checks++; if (fetch_err_o !== 1'b0) $display("FAIL ferr_cleared: got %b want 0", fetch_err_o); else passed++;
      tx_q.delete();
      for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
      send_bytes(-1, 1'b0, early, fin);
      model_load(1);
      tick();
      inst_addr_i = 32'h0; #1;
      checks++; if (inst_o !== model_mem[0]) $display("FAIL ferr_reload_word0: got %h want %h", inst_o, model_mem[0]); else passed++;
      tick();
   endtask

   task automatic test_reset_mid_load();
      int   early;
      logic fin;
      tx_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93};
      start_load(2);
      send_bytes(0, 1'b0, early, fin);
      model_load(2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (ld_ready_o !== 1'b0 || ld_busy_o !== 1'b0) $display("FAIL midrst_flags: got ready=%b busy=%b want 0 0", ld_ready_o, ld_busy_o); else passed++;
`ifndef INST_MEM_PRELOAD_EN
      checks++; if (cpu_rst_n_o !== 1'b0 || inst_o !== NOP) $display("FAIL midrst_idle: got cpu=%b inst=%h want 0 %h", cpu_rst_n_o, inst_o, NOP); else passed++;
`endif
      start_load(1);
      tx_q.delete();
      for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
      send_bytes(0, 1'b0, early, fin);
      model_load(1);
      checks++; if (fin !== 1'b1) $display("FAIL midrst_done: got %b want 1", fin); else passed++;
      tick();
      inst_addr_i = 32'h0; #1;
      checks++; if (inst_o !== model_mem[0]) $display("FAIL midrst_word0: got %h want %h", inst_o, model_mem[0]); else passed++;
      inst_addr_i = 32'h4; #1;
      checks++; if (inst_o !== model_mem[1]) $display("FAIL midrst_word1: got %h want %h", inst_o, model_mem[1]); else passed++;
      inst_addr_i = 32'h0;
      tick();
   endtask

   // Random lengths, bytes and gaps; ld_start_i is toggled mid-load and must be ignored.
   task automatic test_random_loads();
      int   early;
      logic fin;
      int   len;
      for (int it = 0; it < 5; it++) begin
         len = $urandom_range(1, 6);
         tx_q.delete();
         for (int i = 0; i < 4 * len; i++) tx_q.push_back(8'($urandom));
         start_load(len);
         send_bytes(-1, 1'b1, early, fin);
         model_load(len);
         checks++; if (early !== 0 || fin !== 1'b1) $display("FAIL rand%0d_done: got early=%0d final=%b want 0 1", it, early, fin); else passed++;
         tick();
         for (int w = 0; w < 8; w++) begin
            if (model_known[w]) begin
               inst_addr_i = 32'(4 * w); #1;
               checks++; if (inst_o !== model_mem[w]) $display("FAIL rand%0d_word%0d: got %h want %h", it, w, inst_o, model_mem[w]); else passed++;
               tick();
            end
         end
         inst_addr_i = 32'h0;
      end
   endtask

   // Oversized length clamps to the full array depth.
   task automatic test_clamp();
      int   early;
      logic fin;
      int   w;
      tx_q.delete();
      for (int i = 0; i < 4 * DEPTH; i++) tx_q.push_back(8'($urandom));
      start_load(2 * DEPTH - 1);
      send_bytes(0, 1'b0, early, fin);
      model_load(DEPTH);
      checks++; if (early !== 0 || fin !== 1'b1) $display("FAIL clamp_done: got early=%0d final=%b want 0 1", early, fin); else passed++;
      tick();
      checks++; if (cpu_rst_n_o !== 1'b1) $display("FAIL clamp_run: got %b want 1", cpu_rst_n_o); else passed++;
      for (int k = 0; k < 10; k++) begin
         w = (k == 0) ? DEPTH - 1 : (k == 1) ? 0 : $urandom_range(0, DEPTH - 1);
         inst_addr_i = 32'(4 * w); #1;
         checks++; if (inst_o !== model_mem[w]) $display("FAIL clamp_word%0d: got %h want %h", w, inst_o, model_mem[w]); else passed++;
         tick();
      end
      inst_addr_i = 32'h0;
   endtask

   initial begin
      rst_n       = 1'b0;
      inst_addr_i = 32'h0;
      ld_start_i  = 1'b0;
      ld_len_i    = '0;
      ld_valid_i  = 1'b0;
      ld_data_i   = 8'h0;
      for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
      test_reset();
      test_known_load("b2b", 0);
      test_known_load("gap", 3);
      test_fetch_err();
      test_reset_mid_load();
      test_random_loads();
      test_clamp();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
